help_call_responder: RTL and testbench
======================================

HELP_CALL_RESPONDER -- requirements
Module: help_call_responder

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 50_000, giving the cycles an input must be stable before it is accepted (1 ms at 50 MHz).
REQ-002 The block SHALL have parameter ACK_HOLD_CYCLES, default 2_500_000, giving the length of the acknowledge pulse returned to the remote unit.
REQ-003 The block SHALL have parameter ESCALATE_CYCLES, default 25_000_000, giving the unacknowledged ringing time before escalation.
REQ-004 The block SHALL have parameter BLINK_BIT, default 22, selecting the timer bit that drives the buzzer cadence.
REQ-005 clk  input  1  50 MHz system clock; the block has one clock and reset is asynchronous and active-high.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 call_help_n  input  1  active-low help request from a remote emergency unit; asynchronous to clk.
REQ-008 ack_btn_n  input  1  active-low operator acknowledge button; asynchronous to clk.
REQ-009 buzzer_pin  output  1  active-low operator buzzer.
REQ-010 ring_led_pin  output  1  active-low call indicator LED.
REQ-011 ack_out_n  output  1  active-low acknowledge line returned to the remote unit.
REQ-012 escalate_pin  output  1  active-low escalation output to a secondary responder.
REQ-013 call_count  output  8  number of accepted calls, saturating.

Function
REQ-014 Each asynchronous input SHALL pass through a 2-flop synchronizer, then a debouncer that changes its output only after DEBOUNCE_CYCLES consecutive equal synchronized samples.
REQ-015 The debounced signals SHALL be call_active (the inverse of call_help_n) and ack_edge (a one-cycle pulse on the debounced ack press, inactive to active).
REQ-016 The FSM SHALL have the states IDLE, RINGING, ESCALATED, ACKED and WAIT_CLEAR; the state SHALL be registered and all outputs SHALL decode from the state (Moore).
REQ-017 A timer SHALL clear to 0 on every state change and SHALL otherwise increment by 1 each cycle, saturating at all-ones; it SHALL be 25 bits wide.
REQ-018 IDLE: call_active SHALL cause a transition to RINGING and SHALL increment call_count by 1 in the same cycle, saturating at 255.
REQ-019 RINGING: the transitions SHALL follow this priority: ack_edge goes to ACKED; otherwise !call_active (remote cancel) goes to IDLE; otherwise timer == ESCALATE_CYCLES-1 goes to ESCALATED.
REQ-020 ESCALATED: ack_edge SHALL go to ACKED; otherwise !call_active SHALL go to IDLE.
REQ-021 ACKED: timer == ACK_HOLD_CYCLES-1 SHALL go to WAIT_CLEAR; ack_edge and cancel SHALL be ignored in this state.
REQ-022 WAIT_CLEAR: !call_active SHALL go to IDLE; ack_edge SHALL be ignored.
REQ-023 ack_edge in IDLE SHALL have no effect.
REQ-024 A call that reasserts in WAIT_CLEAR SHALL NOT be counted; only the IDLE to RINGING transition counts.
REQ-025 Output decode: buzzer SHALL be active when timer[BLINK_BIT]==0 in RINGING and continuously active in ESCALATED.
REQ-026 Output decode: ring_led SHALL be active in RINGING, ESCALATED and ACKED.
REQ-027 Output decode: ack_out SHALL be active only in ACKED.
REQ-028 Output decode: escalate SHALL be active only in ESCALATED.
REQ-029 Output decode: all outputs SHALL be inactive (high) in IDLE and WAIT_CLEAR.
REQ-030 Latency from a stable call_help_n low to RINGING SHALL be 2 synchronizer cycles + DEBOUNCE_CYCLES + 1 cycle, ±1 cycle.

Reset
REQ-031 While reset is high, state SHALL be IDLE, the timer and call_count SHALL be 0, and the synchronizer and debouncer flops SHALL hold the inactive level.
REQ-032 While reset is high, all active-low outputs SHALL be 1.
REQ-033 Reset asserted mid-call SHALL immediately release ack_out_n and escalate_pin.
REQ-034 After reset deasserts with call_help_n still low, the call SHALL be re-accepted after the debounce time and counted once.

Configuration
REQ-035 Macro RESPONDER_ESCALATE_EN: when defined, ESCALATED and the RINGING to ESCALATED transition SHALL exist.
REQ-036 When RESPONDER_ESCALATE_EN is undefined, RINGING SHALL wait indefinitely for an ack or cancel, and escalate_pin SHALL be tied to 1.

Structure
REQ-037 A shared package SHALL hold the state typedef (3-bit enum) and the default timeout constants.
REQ-038 The synchronizer and debouncer SHALL be a sub-module, sync_debounce, instantiated twice with parameters DEBOUNCE_CYCLES and RESET_LEVEL.

Verification
REQ-039 The bench SHALL use DEBOUNCE=4, ACK_HOLD=8, ESCALATE=20 and BLINK_BIT=2 for all scenarios.
REQ-040 Scenario: call_help_n low for 3 cycles -> no state change, call_count=0.
REQ-041 Scenario: call_help_n held low, then ack pressed 6 cycles after RINGING is entered -> ACKED, ack_out_n low for exactly 8 cycles, WAIT_CLEAR, then call_help_n released -> IDLE, call_count=1.
REQ-042 Scenario: call held with no ack and the macro defined -> ESCALATED 20 cycles after RINGING is entered, escalate_pin=0, buzzer steady low; without the macro -> still RINGING at cycle 100.
REQ-043 Scenario: call released while RINGING -> IDLE with ack_out_n never asserted; 256 separate calls -> call_count=255.
REQ-044 Scenario: reset asserted in ACKED -> all outputs 1 in the same cycle; call still low after release -> RINGING again, call_count=1.

Source files
------------

// File: rtl/help_call_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : help_call_responder_pkg
//  Description : Shared types and default timing constants for the help-call
//                responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package help_call_responder_pkg;

    // Call-handling FSM states
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RINGING    = 3'd1,
        ST_ESCALATED  = 3'd2,
        ST_ACKED      = 3'd3,
        ST_WAIT_CLEAR = 3'd4
    } state_t;

    // Default timing at a 50 MHz system clock
    localparam int DEF_DEBOUNCE_CYCLES = 50_000;      // 1 ms
    localparam int DEF_ACK_HOLD_CYCLES = 2_500_000;   // 50 ms
    localparam int DEF_ESCALATE_CYCLES = 25_000_000;  // 500 ms
    localparam int DEF_BLINK_BIT       = 22;

    localparam int TIMER_W = 25;
    localparam int COUNT_W = 8;

endpackage : help_call_responder_pkg
`default_nettype wire

// File: rtl/help_call_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : help_call_responder_if
//  Description : Pin bundle between the remote unit / operator panel and the
//                help-call responder. All single-bit pins are active-low.
//  Revision    : 1.0 - initial release
// ============================================================================
interface help_call_responder_if;

    logic       call_help_n;
    logic       ack_btn_n;
    logic       buzzer_pin;
    logic       ring_led_pin;
    logic       ack_out_n;
    logic       escalate_pin;
    logic [7:0] call_count;

    // Responder side
    modport slave (
        input  call_help_n,
        input  ack_btn_n,
        output buzzer_pin,
        output ring_led_pin,
        output ack_out_n,
        output escalate_pin,
        output call_count
    );

    // Environment side (remote unit, operator panel, test bench)
    modport master (
        output call_help_n,
        output ack_btn_n,
        input  buzzer_pin,
        input  ring_led_pin,
        input  ack_out_n,
        input  escalate_pin,
        input  call_count
    );

endinterface : help_call_responder_if
`default_nettype wire

// File: rtl/help_call_responder_sync_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : sync_debounce
//  Description : Two-flop synchronizer followed by a debouncer whose output
//                follows the synchronized input only after DEBOUNCE_CYCLES
//                consecutive samples that differ from the current output.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_debounce #(
    parameter int DEBOUNCE_CYCLES = 50_000,
    parameter bit RESET_LEVEL     = 1'b1
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic din_i,
    output logic      dout_o
);

    localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    logic             db_q;
    logic [CNT_W-1:0] cnt_q;

    // Bring the asynchronous pin into the clock domain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= RESET_LEVEL;
            sync_q <= RESET_LEVEL;
        end else begin
            meta_q <= din_i;
            sync_q <= meta_q;
        end
    end

    // Count consecutive differing samples; accept the new level on the last one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_q  <= RESET_LEVEL;
            cnt_q <= '0;
        end else if (sync_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_q  <= sync_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else begin
            cnt_q <= '0;
        end
    end

    assign dout_o = db_q;

endmodule : sync_debounce
`default_nettype wire

// File: rtl/help_call_responder.sv
`default_nettype none
// ============================================================================
//  Module      : help_call_responder
//  Description : Emergency help-call responder. Debounces the remote call and
//                operator acknowledge inputs, rings the operator, returns an
//                acknowledge pulse to the remote unit and counts calls.
//                Optional feature macro: RESPONDER_ESCALATE_EN - when defined,
//                an unacknowledged call escalates to a secondary responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module help_call_responder
    import help_call_responder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int ACK_HOLD_CYCLES = DEF_ACK_HOLD_CYCLES,
    parameter int ESCALATE_CYCLES = DEF_ESCALATE_CYCLES,
    parameter int BLINK_BIT       = DEF_BLINK_BIT
) (
    input  wire logic             clk,
    input  wire logic             reset,
    help_call_responder_if.slave  bus
);

    localparam logic [TIMER_W-1:0] ACK_LAST = TIMER_W'(ACK_HOLD_CYCLES - 1);
`ifdef RESPONDER_ESCALATE_EN
    localparam logic [TIMER_W-1:0] ESC_LAST = TIMER_W'(ESCALATE_CYCLES - 1);
`endif

    logic               call_db;
    logic               ack_db;
    logic               ack_prev_q;
    logic               call_active;
    logic               ack_edge;

    state_t             state_q;
    state_t             state_d;
    logic [TIMER_W-1:0] timer_q;
    logic [TIMER_W-1:0] timer_d;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;

    logic               buzzer_n;
    logic               ring_led_n;
    logic               ack_out_n;
    logic               escalate_n;

    sync_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_LEVEL     (1'b1)
    ) u_call_db (
        .clk    (clk),
        .reset  (reset),
        .din_i  (bus.call_help_n),
        .dout_o (call_db)
    );

    sync_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_LEVEL     (1'b1)
    ) u_ack_db (
        .clk    (clk),
        .reset  (reset),
        .din_i  (bus.ack_btn_n),
        .dout_o (ack_db)
    );

    assign call_active = ~call_db;
    // Press = debounced level falling from released (1) to pressed (0)
    assign ack_edge    = ack_prev_q & ~ack_db;

    // State, timer, call counter and ack edge-detect registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            count_q    <= '0;
            ack_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            count_q    <= count_d;
            ack_prev_q <= ack_db;
        end
    end

    // Next-state decision
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (call_active) state_d = ST_RINGING;
            end
            ST_RINGING: begin
                if (ack_edge)          state_d = ST_ACKED;
                else if (!call_active) state_d = ST_IDLE;
`ifdef RESPONDER_ESCALATE_EN
                else if (timer_q == ESC_LAST) state_d = ST_ESCALATED;
`endif
            end
            ST_ESCALATED: begin
`ifdef RESPONDER_ESCALATE_EN
                if (ack_edge)          state_d = ST_ACKED;
                else if (!call_active) state_d = ST_IDLE;
`else
                // Unreachable without escalation; recover to a safe state
                state_d = ST_IDLE;
`endif
            end
            ST_ACKED: begin
                if (timer_q == ACK_LAST) state_d = ST_WAIT_CLEAR;
            end
            ST_WAIT_CLEAR: begin
                if (!call_active) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Timer restarts on every state change, otherwise counts up and saturates;
    // only the IDLE to RINGING transition counts as a new call
    always_comb begin
        if (state_d != state_q)  timer_d = '0;
        else if (&timer_q)       timer_d = timer_q;
        else                     timer_d = timer_q + 1'b1;

        count_d = count_q;
        if ((state_q == ST_IDLE) && (state_d == ST_RINGING) && !(&count_q))
            count_d = count_q + 1'b1;
    end

    // Moore output decode, all active-low
    always_comb begin
        buzzer_n   = 1'b1;
        ring_led_n = 1'b1;
        ack_out_n  = 1'b1;
        escalate_n = 1'b1;
        case (state_q)
            ST_RINGING: begin
                buzzer_n   = timer_q[BLINK_BIT];
                ring_led_n = 1'b0;
            end
            ST_ESCALATED: begin
`ifdef RESPONDER_ESCALATE_EN
                buzzer_n   = 1'b0;
                ring_led_n = 1'b0;
                escalate_n = 1'b0;
`endif
            end
            ST_ACKED: begin
                ring_led_n = 1'b0;
                ack_out_n  = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus.buzzer_pin   = buzzer_n;
    assign bus.ring_led_pin = ring_led_n;
    assign bus.ack_out_n    = ack_out_n;
`ifdef RESPONDER_ESCALATE_EN
    assign bus.escalate_pin = escalate_n;
`else
    assign bus.escalate_pin = 1'b1;
`endif
    assign bus.call_count   = count_q;

endmodule : help_call_responder
`default_nettype wire

// File: tb/tb_help_call_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_help_call_responder
//  Description : Self-checking bench for help_call_responder. Expected pin
//                states and call counts are queued when stimulus is applied
//                and compared when the responder reaches the awaited point.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_help_call_responder;

    localparam int DEB   = 4;
    localparam int ACKH  = 8;
    localparam int ESC   = 20;
    localparam int BLINK = 2;

    typedef struct {
        logic [3:0] pins;   // {buzzer, ring_led, ack_out_n, escalate}
        logic [7:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    exp_t sb_q[$];
    int   n_total = 0;
    int   n_bad   = 0;
    int   exp_cnt = 0;

    always #5 clk = ~clk;

    help_call_responder_if bus ();

    help_call_responder #(
        .DEBOUNCE_CYCLES (DEB),
        .ACK_HOLD_CYCLES (ACKH),
        .ESCALATE_CYCLES (ESC),
        .BLINK_BIT       (BLINK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [3:0] pins_now();
        return {bus.buzzer_pin, bus.ring_led_pin, bus.ack_out_n, bus.escalate_pin};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [3:0] pins, input int cnt);
        exp_t e;
        e.pins = pins;
        e.cnt  = 8'(cnt);
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_eq({tag, "_pins"}, 32'(pins_now()), 32'(e.pins));
            check_eq({tag, "_cnt"}, 32'(bus.call_count), 32'(e.cnt));
        end
    endtask

    task automatic model_call();
        if (exp_cnt < 255) exp_cnt++;
    endtask

    task automatic wait_ring(input string tag, input int max);
        int i = 0;
        while (bus.ring_led_pin !== 1'b0 && i < max) begin
            tick();
            i++;
        end
        check_eq(tag, 32'(bus.ring_led_pin), 32'd0);
    endtask

    task automatic wait_ack_low(input string tag, input int max);
        int i = 0;
        while (bus.ack_out_n !== 1'b0 && i < max) begin
            tick();
            i++;
        end
        check_eq(tag, 32'(bus.ack_out_n), 32'd0);
    endtask

    initial begin
        int n;
        bit saw_ack;
        bus.call_help_n = 1'b1;
        bus.ack_btn_n   = 1'b1;
        reset           = 1'b1;
        tick();
        tick();
        push_exp(4'b1111, 0);
        sb_check("reset");
        reset = 1'b0;
        tick();

        // Short glitch on the call line is rejected
        bus.call_help_n = 1'b0;
        repeat (3) tick();
        bus.call_help_n = 1'b1;
        repeat (12) tick();
        push_exp(4'b1111, 0);
        sb_check("glitch");

        // Call, ack 6 cycles into ringing, ack pulse, wait-clear, release
        bus.call_help_n = 1'b0;
        model_call();
        push_exp(4'b0011, exp_cnt);
        wait_ring("s2_ring_to", 30);
        sb_check("s2_ring_entry");
        repeat (4) tick();
        push_exp(4'b1011, exp_cnt);
        sb_check("s2_blink_off");
        repeat (2) tick();
        bus.ack_btn_n = 1'b0;
        push_exp(4'b1001, exp_cnt);
        wait_ack_low("s2_ack_to", 30);
        sb_check("s2_acked");
        n = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.ack_out_n === 1'b0) n++;
            else break;
        end
        check_eq("s2_ack_len", 32'(n), 32'(ACKH));
        push_exp(4'b1111, exp_cnt);
        sb_check("s2_wait_clear");
        bus.ack_btn_n = 1'b1;
        repeat (10) tick();
        push_exp(4'b1111, exp_cnt);
        sb_check("s2_wc_hold");
        bus.call_help_n = 1'b1;
        repeat (10) tick();
        push_exp(4'b1111, exp_cnt);
        sb_check("s2_idle");
        bus.ack_btn_n = 1'b0;
        repeat (10) tick();
        bus.ack_btn_n = 1'b1;
        repeat (10) tick();
        push_exp(4'b1111, exp_cnt);
        sb_check("s2_ack_in_idle");

        // Unanswered call
        bus.call_help_n = 1'b0;
        model_call();
        push_exp(4'b0011, exp_cnt);
        wait_ring("s3_ring_to", 30);
        sb_check("s3_ring_entry");
`ifdef RESPONDER_ESCALATE_EN
        repeat (ESC - 1) tick();
        push_exp(4'b0011, exp_cnt);
        sb_check("s3_pre_esc");
        tick();
        push_exp(4'b0010, exp_cnt);
        sb_check("s3_escalated");
        repeat (7) tick();
        push_exp(4'b0010, exp_cnt);
        sb_check("s3_esc_steady");
`else
        repeat (100) tick();
        push_exp(4'b1011, exp_cnt);
        sb_check("s3_still_ringing");
`endif
        bus.call_help_n = 1'b1;
        repeat (10) tick();
        push_exp(4'b1111, exp_cnt);
        sb_check("s3_idle");

        // Remote cancel while ringing: no acknowledge pulse
        bus.call_help_n = 1'b0;
        model_call();
        wait_ring("s4_ring_to", 30);
        bus.call_help_n = 1'b1;
        saw_ack = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.ack_out_n === 1'b0) saw_ack = 1'b1;
        end
        check_eq("s4_no_ack", 32'(saw_ack), 32'd0);
        push_exp(4'b1111, exp_cnt);
        sb_check("s4_cancel_idle");

        // Counter saturation
        for (int k = 0; k < 256; k++) begin
            bus.call_help_n = 1'b0;
            model_call();
            wait_ring("s4_loop_ring_to", 30);
            bus.call_help_n = 1'b1;
            repeat (10) tick();
        end
        push_exp(4'b1111, exp_cnt);
        sb_check("s4_saturate");
        check_eq("s4_count_255", 32'(bus.call_count), 32'd255);

        // Reset during ACKED, then re-acceptance of the held call
        reset = 1'b1;
        exp_cnt = 0;
        tick();
        push_exp(4'b1111, exp_cnt);
        sb_check("s5_reset_clear");
        reset = 1'b0;
        tick();
        bus.call_help_n = 1'b0;
        model_call();
        wait_ring("s5_ring_to", 30);
        bus.ack_btn_n = 1'b0;
        push_exp(4'b1001, exp_cnt);
        wait_ack_low("s5_ack_to", 30);
        sb_check("s5_acked");
        reset = 1'b1;
        exp_cnt = 0;
        push_exp(4'b1111, exp_cnt);
        #1;
        sb_check("s5_reset_async");
        bus.ack_btn_n = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_call();
        push_exp(4'b0011, exp_cnt);
        wait_ring("s5_reacq_to", 30);
        sb_check("s5_reacquired");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

endmodule : tb_help_call_responder
`default_nettype wire
